hex_card_monitor: RTL and testbench
===================================

Name: hex_card_monitor

Overview:
- Reader side of the card-display interface of the lab1 baccarat datapath. lab1 writes the dealt cards to HEX0..HEX5; this block reads them back.
- Samples the six active-low seven-segment displays after each deal step, decodes each pattern to a card value and enforces the deal order.
- Recomputes player and dealer baccarat scores and flags any illegal pattern or illegal display change.
- Synthesizable; used in benches and, optionally, on-board as a self-check.

Parameters:
- SETTLE, 2, clk cycles between deal_strobe and the display sample (1..15)
- CNT_W, 4, width of the settle counter

Ports:
- clk  in  1  system clock
- resetb  in  1  asynchronous active-low reset
- deal_strobe  in  1  one-clk pulse per deal step (synchronised KEY[0] press)
- hex0..hex5  in  7 each  active-low segments gfedcba; hex0-2 = player cards 1-3, hex3-5 = dealer cards 1-3
- pscore  out  4  player score, (sum of card values) mod 10
- dscore  out  4  dealer score, (sum of card values) mod 10
- card_count  out  3  number of cards shown, 0..6
- sample_valid  out  1  one-clk pulse when a sample has been checked
- err  out  1  sticky error flag
- err_code  out  3  first error: 0 none, 1 bad pattern, 2 out-of-order card, 3 shown card changed, 4 more than one new card in a sample

Behaviour:
- Reset (async, resetb=0): all outputs 0; state IDLE; the card shadow registers for all six slots are blank.
- Decode table:
  - blank 1111111 -> empty
  - A 0001000 = 1; 2 0100100; 3 0110000; 4 0011001; 5 0010010; 6 0000010; 7 1111000; 8 0000000; 9 0010000
  - 10 shown as "0", 1000000 = 0; J 1100001, Q 0011000, K 0001001 = 0
  - Any other pattern is a bad pattern.
  - Shadow registers hold the raw 7-bit pattern, not the decoded value, so 10/J/Q/K changes are detected.
- FSM IDLE -> WAIT -> CHECK -> IDLE:
  - IDLE: on deal_strobe, load the counter with SETTLE and go to WAIT.
  - WAIT: count down; at 0 register all six hex inputs and go to CHECK.
  - CHECK, one cycle:
    - classify each slot;
    - update the shadows, card_count, pscore and dscore;
    - pulse sample_valid;
    - return to IDLE.
- Latency: sample_valid asserts SETTLE+2 clks after the deal_strobe cycle.
- Legal slot order: hex0, hex3, hex1, hex4, then hex2 and hex5 in either order.
  - A new non-blank slot whose predecessors, per this order, are not all non-blank -> code 2.
- A shadowed non-blank slot that now differs, including going blank -> code 3.
- More than one slot newly non-blank in a single sample -> code 4.
- Priority when several errors occur in the same CHECK: 1 > 3 > 2 > 4.
- err and err_code latch on the first error and hold until reset.
- Scores and card_count still update from every valid, decodable slot after an error.
- Score arithmetic: sum the 3 slot values in 5 bits, then take mod 10 via a compare/subtract chain. Maximum sum is 27.
- deal_strobe during WAIT or CHECK is ignored.
- resetb low mid-sample aborts to IDLE immediately; there is no sample_valid pulse.
- A 7th card is impossible; card_count saturates at 6.

Optional Feature:
- Macro: HEX_MONITOR_WINNER_EN.
- When defined:
  - Adds input ledr_win[1:0] (LEDR[9:8]) and outputs win_exp[1:0] and win_mismatch (1 bit, sticky).
  - In each CHECK with card_count==6, or with card_count==4 and either score >=8, win_exp is computed:
    - pscore>dscore -> 01
    - dscore>pscore -> 10
    - equal -> 11
  - win_exp is compared with ledr_win; on inequality win_mismatch is set.
  - win_exp and win_mismatch reset to 0.
- When undefined: these ports and their logic are absent.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then no strobe: all outputs 0; SETTLE=2 strobe with all blank -> sample_valid at clk 4 after the strobe, card_count 0, err 0.
- Four strobes showing hex0=7, hex3=K, hex1=5, hex4=9 in order -> card_count 4, pscore 2, dscore 9, err 0.
- Deal continues with hex2=8, hex5=A -> card_count 6, pscore 0, dscore 0; with WINNER_EN and ledr_win=11 -> win_mismatch 0; with ledr_win=01 -> win_mismatch 1.
- First sample shows hex1=3 while hex0 is blank -> err 1, err_code 2, pscore 3.
- hex0 shows 1111110 -> err_code 1. Separately, in another run: hex0 changes from J to Q -> err_code 3.
- resetb pulsed low during WAIT -> outputs 0 asynchronously, no sample_valid pulse; the next strobe samples normally.

Source files
------------

// File: rtl/hex_card_monitor.sv
// hex_card_monitor: reads back the six active-low card displays of the
// baccarat datapath after each deal step, decodes the cards, checks the deal
// order, recomputes both baccarat scores and latches the first error seen.
// Optional build macro: HEX_MONITOR_WINNER_EN adds the expected-winner check
// against the LEDR[9:8] winner lights.
module hex_card_monitor #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 4
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       deal_strobe,
  input  logic [6:0] hex0,
  input  logic [6:0] hex1,
  input  logic [6:0] hex2,
  input  logic [6:0] hex3,
  input  logic [6:0] hex4,
  input  logic [6:0] hex5,
`ifdef HEX_MONITOR_WINNER_EN
  input  logic [1:0] ledr_win,
  output logic [1:0] win_exp,
  output logic       win_mismatch,
`endif
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] card_count,
  output logic       sample_valid,
  output logic       err,
  output logic [2:0] err_code
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;

  localparam logic [6:0] BLANK = 7'h7f;

  // Slots that must already be showing before a slot may appear.
  // Deal order: hex0, hex3, hex1, hex4, then hex2 / hex5 in either order.
  localparam logic [5:0][5:0] PRED = {6'b011011, 6'b001011, 6'b000001,
                                      6'b011011, 6'b001001, 6'b000000};

  function automatic logic is_card(input logic [6:0] p);
    case (p)
      7'b0001000, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
      7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000,
      7'b1000000, 7'b1100001, 7'b0011000, 7'b0001001: is_card = 1'b1;
      default:                                         is_card = 1'b0;
    endcase
  endfunction

  // Baccarat value of a pattern; 10/J/Q/K and anything non-card give 0.
  function automatic logic [3:0] card_val(input logic [6:0] p);
    case (p)
      7'b0001000: card_val = 4'd1;
      7'b0100100: card_val = 4'd2;
      7'b0110000: card_val = 4'd3;
      7'b0011001: card_val = 4'd4;
      7'b0010010: card_val = 4'd5;
      7'b0000010: card_val = 4'd6;
      7'b1111000: card_val = 4'd7;
      7'b0000000: card_val = 4'd8;
      7'b0010000: card_val = 4'd9;
      default:    card_val = 4'd0;
    endcase
  endfunction

  // Sum of three cards is at most 27, so two conditional subtracts suffice.
  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] t;
    t = s;
    if (t >= 5'd20) t = t - 5'd20;
    if (t >= 5'd10) t = t - 5'd10;
    mod10 = t[3:0];
  endfunction

  logic [1:0]       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0][6:0]  smp_q, sh_q, sh_d, hex_in;
  logic [3:0]       pscore_q, dscore_q, ps_d, ds_d;
  logic [2:0]       count_q, count_d, code_q, code_d, nnew;
  logic             sv_q, err_q;
  logic [5:0]       bad, chg, newc, nonblk, ooo;
  logic [5:0][3:0]  sval;
  logic [4:0]       psum, dsum;

  assign hex_in = {hex5, hex4, hex3, hex2, hex1, hex0};

  // Classify every sampled slot against its shadow and derive the next
  // shadows, scores, card count and error code for the CHECK cycle.
  always_comb begin
    nnew    = 3'd0;
    count_d = 3'd0;
    for (int i = 0; i < 6; i++) begin
      nonblk[i] = (smp_q[i] != BLANK);
      bad[i]    = nonblk[i] && !is_card(smp_q[i]);
      chg[i]    = (sh_q[i] != BLANK) && (smp_q[i] != sh_q[i]);
      newc[i]   = (sh_q[i] == BLANK) && nonblk[i] && !bad[i];
      // A bad pattern never enters the shadow so scores stay meaningful.
      sh_d[i]   = bad[i] ? sh_q[i] : smp_q[i];
      sval[i]   = card_val(sh_d[i]);
      nnew      = nnew + {2'd0, newc[i]};
      count_d   = count_d + {2'd0, (sh_d[i] != BLANK)};
    end
    for (int i = 0; i < 6; i++)
      ooo[i] = newc[i] && ((nonblk & PRED[i]) != PRED[i]);
    if (count_d > 3'd6) count_d = 3'd6;
    psum = {1'b0, sval[0]} + {1'b0, sval[1]} + {1'b0, sval[2]};
    dsum = {1'b0, sval[3]} + {1'b0, sval[4]} + {1'b0, sval[5]};
    ps_d = mod10(psum);
    ds_d = mod10(dsum);
    if (|bad)             code_d = 3'd1;
    else if (|chg)        code_d = 3'd3;
    else if (|ooo)        code_d = 3'd2;
    else if (nnew > 3'd1) code_d = 3'd4;
    else                  code_d = 3'd0;
  end

  // Strobe -> settle countdown -> sample -> one-cycle check.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      smp_q   <= {6{BLANK}};
    end else begin
      case (state_q)
        S_IDLE: if (deal_strobe) begin
          cnt_q   <= CNT_W'(SETTLE);
          state_q <= S_WAIT;
        end
        S_WAIT: if (cnt_q == '0) begin
          smp_q   <= hex_in;
          state_q <= S_CHECK;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Commit the check results; err/err_code keep the first error until reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sh_q     <= {6{BLANK}};
      pscore_q <= '0;
      dscore_q <= '0;
      count_q  <= '0;
      sv_q     <= 1'b0;
      err_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      sv_q <= (state_q == S_CHECK);
      if (state_q == S_CHECK) begin
        sh_q     <= sh_d;
        pscore_q <= ps_d;
        dscore_q <= ds_d;
        count_q  <= count_d;
        if (!err_q && code_d != 3'd0) begin
          err_q  <= 1'b1;
          code_q <= code_d;
        end
      end
    end
  end

`ifdef HEX_MONITOR_WINNER_EN
  logic [1:0] win_q, win_d;
  logic       wmis_q;

  always_comb begin
    if (ps_d > ds_d)      win_d = 2'b01;
    else if (ds_d > ps_d) win_d = 2'b10;
    else                  win_d = 2'b11;
  end

  // Judge the winner lights once the hand is decided (6 cards or a natural).
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      win_q  <= '0;
      wmis_q <= 1'b0;
    end else if (state_q == S_CHECK &&
                 (count_d == 3'd6 ||
                  (count_d == 3'd4 && (ps_d >= 4'd8 || ds_d >= 4'd8)))) begin
      win_q <= win_d;
      if (win_d != ledr_win) wmis_q <= 1'b1;
    end
  end

  assign win_exp      = win_q;
  assign win_mismatch = wmis_q;
`endif

  assign pscore       = pscore_q;
  assign dscore       = dscore_q;
  assign card_count   = count_q;
  assign sample_valid = sv_q;
  assign err          = err_q;
  assign err_code     = code_q;

endmodule

// File: tb/tb_hex_card_monitor.sv
// Scoreboard bench for hex_card_monitor: each deal step pushes its expected
// result, the step waits for sample_valid and the scenario pops and compares.
module tb_hex_card_monitor;

  localparam logic [6:0] BL = 7'h7f, CA = 7'b0001000, C2 = 7'b0100100,
    C3 = 7'b0110000, C5 = 7'b0010010, C7 = 7'b1111000, C8 = 7'b0000000,
    C9 = 7'b0010000, CJ = 7'b1100001, CQ = 7'b0011000, CK = 7'b0001001,
    BADP = 7'b1111110;

  typedef struct packed {
    logic [2:0] cnt;
    logic [3:0] ps;
    logic [3:0] ds;
    logic       er;
    logic [2:0] code;
    logic [4:0] lat;
  } res_t;

  logic       clk = 1'b0, resetb = 1'b0, deal_strobe = 1'b0;
  logic [6:0] hex0 = BL, hex1 = BL, hex2 = BL, hex3 = BL, hex4 = BL, hex5 = BL;
  logic [3:0] pscore, dscore;
  logic [2:0] card_count, err_code;
  logic       sample_valid, err;
`ifdef HEX_MONITOR_WINNER_EN
  logic [1:0] ledr_win = 2'b00, win_exp;
  logic       win_mismatch;
`endif

  res_t sb[$];
  int   n_cmp = 0, n_bad = 0;

  hex_card_monitor #(.SETTLE(2), .CNT_W(4)) dut (
    .clk(clk), .resetb(resetb), .deal_strobe(deal_strobe),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4),
    .hex5(hex5),
`ifdef HEX_MONITOR_WINNER_EN
    .ledr_win(ledr_win), .win_exp(win_exp), .win_mismatch(win_mismatch),
`endif
    .pscore(pscore), .dscore(dscore), .card_count(card_count),
    .sample_valid(sample_valid), .err(err), .err_code(err_code));

  always #5 clk = ~clk;

  function automatic res_t mk(input int c, input int p, input int d,
                              input int e, input int k);
    mk = '{cnt: 3'(c), ps: 4'(p), ds: 4'(d), er: 1'(e), code: 3'(k), lat: 5'd4};
  endfunction

  function automatic logic [5:0][6:0] hx(input logic [6:0] a0, a1, a2, a3, a4, a5);
    hx = {a5, a4, a3, a2, a1, a0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    resetb = 1'b0; deal_strobe = 1'b0;
    {hex5, hex4, hex3, hex2, hex1, hex0} = {6{BL}};
    sb.delete();
    repeat (2) @(negedge clk);
    resetb = 1'b1;
  endtask

  // Drive one deal step and capture outputs at the sample_valid pulse;
  // lat is the number of clocks from the strobe edge (20 = never came).
  task automatic deal(input logic [5:0][6:0] h, input res_t e, output res_t o);
    int n;
    sb.push_back(e);
    @(negedge clk);
    {hex5, hex4, hex3, hex2, hex1, hex0} = h;
    deal_strobe = 1'b1;
    @(negedge clk);
    deal_strobe = 1'b0;
    n = 0;
    while (sample_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    o = '{cnt: card_count, ps: pscore, ds: dscore, er: err, code: err_code,
          lat: 5'(n)};
  endtask

  task automatic test_reset();
    res_t o, ex;
    do_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({pscore, dscore, card_count, sample_valid, err, err_code} !== 15'd0) begin
      n_bad++;
      $display("FAIL reset_state got %h want 0",
               {pscore, dscore, card_count, sample_valid, err, err_code});
    end
    deal(hx(BL, BL, BL, BL, BL, BL), mk(0, 0, 0, 0, 0), o);
    ex = sb.pop_front();
    n_cmp++;
    if (o !== ex) begin n_bad++; $display("FAIL blank_sample got %h want %h", o, ex); end
    @(negedge clk);
    n_cmp++;
    if (sample_valid !== 1'b0) begin
      n_bad++; $display("FAIL sv_one_cycle got %b want 0", sample_valid);
    end
  endtask

  task automatic test_full_deal();
    logic [5:0][6:0] h[6];
    res_t e[6];
    logic [1:0] lw[6];
    res_t o, ex;
    h[0] = hx(C7, BL, BL, BL, BL, BL); e[0] = mk(1, 7, 0, 0, 0); lw[0] = 2'b00;
    h[1] = hx(C7, BL, BL, CK, BL, BL); e[1] = mk(2, 7, 0, 0, 0); lw[1] = 2'b00;
    h[2] = hx(C7, C5, BL, CK, BL, BL); e[2] = mk(3, 2, 0, 0, 0); lw[2] = 2'b00;
    h[3] = hx(C7, C5, BL, CK, C9, BL); e[3] = mk(4, 2, 9, 0, 0); lw[3] = 2'b10;
    h[4] = hx(C7, C5, C8, CK, C9, BL); e[4] = mk(5, 0, 9, 0, 0); lw[4] = 2'b10;
    h[5] = hx(C7, C5, C8, CK, C9, CA); e[5] = mk(6, 0, 0, 0, 0); lw[5] = 2'b11;
    do_reset();
    for (int i = 0; i < 6; i++) begin
`ifdef HEX_MONITOR_WINNER_EN
      ledr_win = lw[i];
`endif
      deal(h[i], e[i], o);
      ex = sb.pop_front();
      n_cmp++;
      if (o !== ex) begin n_bad++; $display("FAIL deal_step%0d got %h want %h", i, o, ex); end
    end
`ifdef HEX_MONITOR_WINNER_EN
    n_cmp++;
    if ({win_exp, win_mismatch} !== 3'b110) begin
      n_bad++; $display("FAIL win_tie got %b want 110", {win_exp, win_mismatch});
    end
    ledr_win = 2'b01;
    deal(h[5], e[5], o);
    ex = sb.pop_front();
    n_cmp++;
    if (o !== ex || win_mismatch !== 1'b1) begin
      n_bad++; $display("FAIL win_wrong got %h/%b want %h/1", o, win_mismatch, ex);
    end
`else
    if (lw[0] != 2'b00) $display("unexpected winner table");
`endif
  endtask

  task automatic test_errors();
    logic [5:0][6:0] h[9];
    res_t e[9];
    logic [8:0] rst_before;
    res_t o, ex;
    // order error: player card 2 before player card 1
    h[0] = hx(BL, C3, BL, BL, BL, BL); e[0] = mk(1, 3, 0, 1, 2); rst_before[0] = 1;
    // bad pattern, then scores still follow a later valid card
    h[1] = hx(BADP, BL, BL, BL, BL, BL); e[1] = mk(0, 0, 0, 1, 1); rst_before[1] = 1;
    h[2] = hx(C7, BL, BL, BL, BL, BL);   e[2] = mk(1, 7, 0, 1, 1); rst_before[2] = 0;
    // J replaced by Q: same value, different pattern
    h[3] = hx(CJ, BL, BL, BL, BL, BL);   e[3] = mk(1, 0, 0, 0, 0); rst_before[3] = 1;
    h[4] = hx(CQ, BL, BL, BL, BL, BL);   e[4] = mk(1, 0, 0, 1, 3); rst_before[4] = 0;
    // two new cards in one sample
    h[5] = hx(C2, BL, BL, C3, BL, BL);   e[5] = mk(2, 2, 3, 1, 4); rst_before[5] = 1;
    // change plus out-of-order in the same sample: change wins
    h[6] = hx(CJ, BL, BL, BL, BL, BL);   e[6] = mk(1, 0, 0, 0, 0); rst_before[6] = 1;
    h[7] = hx(CQ, BL, BL, BL, C9, BL);   e[7] = mk(2, 0, 9, 1, 3); rst_before[7] = 0;
    // card going blank is a change
    h[8] = hx(BL, BL, BL, BL, C9, BL);   e[8] = mk(1, 0, 9, 1, 3); rst_before[8] = 0;
    for (int i = 0; i < 9; i++) begin
      if (rst_before[i]) do_reset();
      deal(h[i], e[i], o);
      ex = sb.pop_front();
      n_cmp++;
      if (o !== ex) begin n_bad++; $display("FAIL err_case%0d got %h want %h", i, o, ex); end
    end
  endtask

  task automatic test_abort();
    res_t o, ex;
    logic seen;
    do_reset();
    deal(hx(BL, C3, BL, BL, BL, BL), mk(1, 3, 0, 1, 2), o);
    ex = sb.pop_front();
    n_cmp++;
    if (o !== ex) begin n_bad++; $display("FAIL abort_pre got %h want %h", o, ex); end
    @(negedge clk);
    {hex1, hex0} = {BL, C7};
    deal_strobe = 1'b1;
    @(negedge clk);
    deal_strobe = 1'b0;
    #2 resetb = 1'b0;
    #1;
    n_cmp++;
    if ({pscore, dscore, card_count, sample_valid, err, err_code} !== 15'd0) begin
      n_bad++;
      $display("FAIL abort_async got %h want 0",
               {pscore, dscore, card_count, sample_valid, err, err_code});
    end
    @(negedge clk);
    resetb = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | sample_valid;
    end
    n_cmp++;
    if (seen !== 1'b0) begin n_bad++; $display("FAIL abort_no_sv got %b want 0", seen); end
    deal(hx(C7, BL, BL, BL, BL, BL), mk(1, 7, 0, 0, 0), o);
    ex = sb.pop_front();
    n_cmp++;
    if (o !== ex) begin n_bad++; $display("FAIL abort_post got %h want %h", o, ex); end
  endtask

  initial begin
    test_reset();
    test_full_deal();
    test_errors();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
